// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and types for the issue hazard scoreboard.
package hazard_scoreboard_pkg;
  localparam logic [4:0] ZERO_REG   = 5'd0;
  localparam int         HZ_MAX_LAT = 4;
  localparam int         HZ_LAT_W   = $clog2(HZ_MAX_LAT + 1);

  typedef logic [HZ_LAT_W-1:0] hz_lat_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] way;
  } hz_fwd_t;
endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One architectural register's remaining-latency counter and producing way.
module hz_sb_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int LAT_W = HZ_LAT_W,
  parameter int WAY_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [LAT_W-1:0] load_lat,
  input  logic [WAY_W-1:0] load_src,
  output logic [LAT_W-1:0] rem,
  output logic [WAY_W-1:0] src
);

  // A new issue overrides the countdown of an older producer.
  always_ff @(posedge clock) begin
    if (reset) begin
      rem <= '0;
      src <= '0;
    end else if (en) begin
      if (load) begin
        rem <= load_lat;
        src <= load_src;
      end else if (rem != '0) begin
        rem <= rem - 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// N-way in-order issue hazard unit: latency scoreboard, issue priority, forwarding selects.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int WAYS     = 3,
  parameter int NUM_REGS = 32,
  parameter int MAX_LAT  = HZ_MAX_LAT,
  parameter int CNT_W    = 16,
  localparam int LAT_W   = $clog2(MAX_LAT + 1),
  localparam int IC_W    = $clog2(WAYS + 1),
  localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             freeze,
  input  logic [WAYS-1:0]                  id_valid,
  input  logic [WAYS-1:0][4:0]             id_rs1,
  input  logic [WAYS-1:0][4:0]             id_rs2,
  input  logic [WAYS-1:0][4:0]             id_dest,
  input  logic [WAYS-1:0][LAT_W-1:0]       id_lat,
  output logic [IC_W-1:0]                  issue_count,
  output logic [IC_W-1:0]                  rollback,
  output logic [WAYS-1:0][1:0]             fwd_valid,
  output logic [WAYS-1:0][1:0][WAY_W-1:0]  fwd_way,
  output logic [CNT_W-1:0]                 stall_cycles
);

  logic [NUM_REGS-1:0][LAT_W-1:0] rem;
  logic [NUM_REGS-1:0][WAY_W-1:0] src;
  logic [NUM_REGS-1:1]            load;
  logic [NUM_REGS-1:1][LAT_W-1:0] load_lat;
  logic [NUM_REGS-1:1][WAY_W-1:0] load_src;
  logic [WAYS-1:0]                blocked;
  logic [IC_W-1:0]                n_acc;
  logic [IC_W-1:0]                n_lead;

  function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
    if (lat == '0) return LAT_W'(1);
    if (32'(lat) > MAX_LAT) return LAT_W'(MAX_LAT);
    return lat;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign rem[0] = '0;
  assign src[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    hz_sb_entry #(.LAT_W(LAT_W), .WAY_W(WAY_W)) u_entry (
      .clock    (clock),
      .reset    (reset),
      .en       (!freeze),
      .load     (load[r]),
      .load_lat (load_lat[r]),
      .load_src (load_src[r]),
      .rem      (rem[r]),
      .src      (src[r])
    );
  end

  // No same-cycle forwarding inside a group, so an older writer of a source blocks.
  always_comb begin
    logic [4:0] s;
    s       = '0;
    blocked = '0;
    for (int w = 0; w < WAYS; w++) begin
      for (int k = 0; k < 2; k++) begin
        s = (k == 0) ? id_rs1[w] : id_rs2[w];
        if (s != ZERO_REG) begin
          if (rem[s] > LAT_W'(1)) blocked[w] = 1'b1;
          for (int j = 0; j < w; j++)
            if (id_valid[j] && id_dest[j] == s) blocked[w] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    logic stop_acc;
    logic stop_lead;
    n_acc     = '0;
    n_lead    = '0;
    stop_acc  = 1'b0;
    stop_lead = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!stop_lead) begin
        if (id_valid[w]) n_lead = IC_W'(w + 1);
        else stop_lead = 1'b1;
      end
      if (!stop_acc) begin
        if (id_valid[w] && !blocked[w]) n_acc = IC_W'(w + 1);
        else stop_acc = 1'b1;
      end
    end
  end

  assign issue_count = (reset || freeze) ? '0 : n_acc;
  assign rollback    = IC_W'(WAYS) - issue_count;

  always_comb begin
    logic [4:0] s;
    hz_fwd_t    f;
    s         = '0;
    f         = '0;
    fwd_valid = '0;
    fwd_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      for (int k = 0; k < 2; k++) begin
        s       = (k == 0) ? id_rs1[w] : id_rs2[w];
        f.valid = !reset && (s != ZERO_REG) && (rem[s] == LAT_W'(1));
        f.way   = f.valid ? 2'(src[s]) : 2'd0;
        fwd_valid[w][k] = f.valid;
        fwd_way[w][k]   = f.way[WAY_W-1:0];
      end
    end
  end

  // Ascending way order lets the youngest accepted writer win a WAW.
  always_comb begin
    load     = '0;
    load_lat = '0;
    load_src = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (IC_W'(w) < issue_count && id_dest[w] != ZERO_REG && 32'(id_dest[w]) < NUM_REGS) begin
        load[id_dest[w]]     = 1'b1;
        load_lat[id_dest[w]] = clamp_lat(id_lat[w]);
        load_src[id_dest[w]] = WAY_W'(w);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) stall_cycles <= '0;
    else if (!freeze && n_acc < n_lead) stall_cycles <= sat_inc(stall_cycles);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed scenarios then random groups vs. a ready-time model.
module tb_hazard_scoreboard;
  localparam int WAYS     = 3;
  localparam int NUM_REGS = 32;
  localparam int MAX_LAT  = 4;
  localparam int LAT_W    = 3;
  localparam int CNT_W    = 5;
  localparam int IC_W     = 2;
  localparam int WAY_W    = 2;

  logic                            clock = 1'b0;
  logic                            reset;
  logic                            freeze;
  logic [WAYS-1:0]                 id_valid;
  logic [WAYS-1:0][4:0]            id_rs1;
  logic [WAYS-1:0][4:0]            id_rs2;
  logic [WAYS-1:0][4:0]            id_dest;
  logic [WAYS-1:0][LAT_W-1:0]      id_lat;
  logic [IC_W-1:0]                 issue_count;
  logic [IC_W-1:0]                 rollback;
  logic [WAYS-1:0][1:0]            fwd_valid;
  logic [WAYS-1:0][1:0][WAY_W-1:0] fwd_way;
  logic [CNT_W-1:0]                stall_cycles;

  hazard_scoreboard #(.WAYS(WAYS), .NUM_REGS(NUM_REGS), .MAX_LAT(MAX_LAT), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .freeze       (freeze),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_dest      (id_dest),
    .id_lat       (id_lat),
    .issue_count  (issue_count),
    .rollback     (rollback),
    .fwd_valid    (fwd_valid),
    .fwd_way      (fwd_way),
    .stall_cycles (stall_cycles)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0]               ic;
    logic [31:0]               rb;
    logic [31:0]               st;
    logic [WAYS-1:0][1:0]      fv;
    logic [WAYS-1:0][1:0][1:0] fw;
  } exp_t;

  exp_t  eq[$];
  string nq[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // Reference model: each register's value reaches the completion bus at an
  // absolute "tick" (ticks advance only on unfrozen cycles). Before that tick it
  // is unavailable, at it the value forwards, after it the regfile holds it.
  longint avail[NUM_REGS];
  int     src_m[NUM_REGS];
  longint tick    = 10;
  int     stall_m = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s.%s: got %0d, expected %0d (t=%0t)", nm, fld, act, req, $time);
    end
  endtask

  function automatic void model_eval(output exp_t e, output int acc, output int lead);
    bit stop, blk;
    int s;
    e = '0;
    lead = 0;
    stop = 0;
    for (int w = 0; w < WAYS; w++) begin
      if (!stop) begin
        if (id_valid[w]) lead = w + 1;
        else stop = 1;
      end
    end
    acc = 0;
    stop = 0;
    for (int w = 0; w < WAYS; w++) begin
      if (!stop) begin
        blk = 0;
        if (!id_valid[w]) stop = 1;
        else begin
          for (int k = 0; k < 2; k++) begin
            s = (k == 0) ? int'(id_rs1[w]) : int'(id_rs2[w]);
            if (s != 0) begin
              if (avail[s] > tick) blk = 1;
              for (int j = 0; j < w; j++)
                if (id_valid[j] && int'(id_dest[j]) == s) blk = 1;
            end
          end
          if (blk) stop = 1;
          else acc = w + 1;
        end
      end
    end
    e.ic = (reset || freeze) ? 0 : acc;
    e.rb = WAYS - e.ic;
    e.st = stall_m;
    for (int w = 0; w < WAYS; w++) begin
      for (int k = 0; k < 2; k++) begin
        s = (k == 0) ? int'(id_rs1[w]) : int'(id_rs2[w]);
        e.fv[w][k] = !reset && s != 0 && avail[s] == tick;
        e.fw[w][k] = e.fv[w][k] ? 2'(src_m[s]) : 2'd0;
      end
    end
  endfunction

  task automatic step(input string nm);
    exp_t e;
    int acc, lead, l, d;
    model_eval(e, acc, lead);
    eq.push_back(e);
    nq.push_back(nm);
    @(posedge clock);
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        avail[r] = 0;
        src_m[r] = 0;
      end
      stall_m = 0;
    end else if (!freeze) begin
      for (int w = 0; w < acc; w++) begin
        d = int'(id_dest[w]);
        if (d != 0) begin
          l = int'(id_lat[w]);
          if (l < 1) l = 1;
          if (l > MAX_LAT) l = MAX_LAT;
          avail[d] = tick + l;
          src_m[d] = w;
        end
      end
      tick++;
      if (acc < lead && stall_m < (1 << CNT_W) - 1) stall_m++;
    end
    #1;
  endtask

  task automatic clr();
    freeze   = 1'b0;
    id_valid = '0;
    id_rs1   = '0;
    id_rs2   = '0;
    id_dest  = '0;
    id_lat   = '0;
  endtask

  task automatic setw(input int w, input bit v, input int r1, input int r2, input int d, input int l);
    id_valid[w] = v;
    id_rs1[w]   = 5'(r1);
    id_rs2[w]   = 5'(r2);
    id_dest[w]  = 5'(d);
    id_lat[w]   = 3'(l);
  endtask

  // Monitor: the DUT's outputs are combinational every cycle; check mid-cycle.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clock);
      if (eq.size() > 0) begin
        e  = eq.pop_front();
        nm = nq.pop_front();
        chk(nm, "issue_count", 32'(issue_count), e.ic);
        chk(nm, "rollback", 32'(rollback), e.rb);
        chk(nm, "stall_cycles", 32'(stall_cycles), e.st);
        for (int w = 0; w < WAYS; w++) begin
          for (int k = 0; k < 2; k++) begin
            chk(nm, $sformatf("fwd_valid[%0d][%0d]", w, k), 32'(fwd_valid[w][k]), 32'(e.fv[w][k]));
            if (e.fv[w][k])
              chk(nm, $sformatf("fwd_way[%0d][%0d]", w, k), 32'(fwd_way[w][k]), 32'(e.fw[w][k]));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < NUM_REGS; r++) begin
      avail[r] = 0;
      src_m[r] = 0;
    end
    clr();
    reset = 1'b1;
    @(posedge clock);
    #1;

    setw(0, 1, 4, 5, 1, 1); setw(1, 1, 6, 7, 2, 1); setw(2, 1, 8, 9, 3, 1);
    step("reset_hold");
    reset = 1'b0;
    step("alu3");

    clr(); setw(0, 1, 10, 11, 5, 2); step("load_x5");
    clr(); setw(0, 1, 5, 0, 12, 1); step("use_x5_stall"); step("use_x5_fwd");

    clr(); setw(0, 1, 13, 14, 3, 1); setw(1, 1, 3, 0, 15, 1); setw(2, 1, 16, 17, 20, 1);
    step("intra_raw");

    clr(); setw(0, 1, 0, 0, 7, 4); step("mult_x7");
    clr(); setw(0, 1, 7, 7, 18, 1);
    repeat (5) step("use_x7");

    clr(); setw(0, 1, 0, 0, 5, 2); step("load_x5_frz");
    clr(); setw(0, 1, 5, 0, 19, 1); freeze = 1'b1;
    repeat (3) step("frozen");
    freeze = 1'b0;
    step("after_freeze"); step("after_freeze_fwd");

    clr(); setw(0, 1, 0, 0, 0, 2); setw(1, 1, 0, 0, 21, 1); setw(2, 1, 0, 0, 0, 3);
    step("zero_reg");

    clr(); setw(0, 1, 0, 0, 9, 4); step("load_x9");
    clr(); setw(0, 1, 9, 0, 22, 1); setw(1, 1, 0, 0, 23, 1); step("stall_x9");
    reset = 1'b1; step("reset_mid");
    reset = 1'b0; step("post_reset");

    clr(); setw(0, 1, 0, 0, 8, 4); setw(1, 1, 0, 0, 8, 1); step("waw");
    clr(); setw(0, 1, 8, 0, 24, 1); step("waw_fwd");

    clr(); setw(0, 1, 0, 0, 6, 7); step("clamp_hi");
    clr(); setw(0, 1, 6, 0, 25, 1);
    repeat (5) step("clamp_use");
    clr(); setw(0, 1, 0, 0, 26, 0); step("lat0");
    clr(); setw(0, 1, 26, 0, 27, 1); step("lat0_use");

    clr(); setw(0, 1, 0, 0, 3, 1); setw(1, 1, 3, 0, 28, 1);
    repeat (40) step("stall_sat");

    repeat (400) begin
      clr();
      for (int w = 0; w < WAYS; w++)
        setw(w, ($urandom % 4) != 0, $urandom % 10, $urandom % 10, $urandom % 10, $urandom % 8);
      freeze = ($urandom % 10) == 0;
      reset  = ($urandom % 40) == 0;
      step("rand");
    end
    reset = 1'b0;
    clr();

    @(negedge clock);
    #1;
    if (eq.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", eq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
